// File: rtl/bus_pkg.sv
// Shared types and constants for the serial slave port and its local memory.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_ADDR   = 3'd1,
        RX_DATA   = 3'd2,
        WRITE     = 3'd3,
        READ_WAIT = 3'd4,
        TX_DATA   = 3'd5
    } slave_state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/slave_bram.sv
// Local word memory: synchronous write, combinational read, out-of-range
// addresses drop writes and read back as zero.
module slave_bram
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];
    logic                  in_range_s;
    logic [IDX_W-1:0]      idx_s;

    assign in_range_s = (int'(addr) < MEM_DEPTH);
    assign idx_s      = addr[IDX_W-1:0];

    // Memory array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we && in_range_s) begin
            mem_r[idx_s] <= wdata;
        end
    end

    // Read port with zero fill outside the populated range.
    always_comb begin
        rdata = '0;
        if (in_range_s) begin
            rdata = mem_r[idx_s];
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/serial_slave_port.sv
// Bit-serial bus slave: shifts in mode/address/data, writes or reads local memory,
// shifts read data out. Optional split indication under macro SERIAL_SLAVE_SPLIT_EN.
module serial_slave_port
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int MEM_DEPTH       = 16,
    parameter int ADDR_WIDTH      = 4,
    parameter int READ_LATENCY    = 2,
    parameter int SPLIT_THRESHOLD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic mode,
    input  logic wr_bus,
    input  logic master_valid,
    output logic slave_ready,
    output logic rd_bus,
    output logic slave_valid,
    input  logic master_ready,
    output logic split
);

    localparam int CNT_W  = $clog2(max_int(ADDR_WIDTH, DATA_WIDTH) + 1);
    localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [CNT_W-1:0]  CNT_ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ADDR_LAST_C = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST_C = CNT_W'(DATA_WIDTH - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE_C  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST_C = WAIT_W'(READ_LATENCY - 1);

`ifdef SERIAL_SLAVE_SPLIT_EN
    localparam logic SPLIT_ON_C = (READ_LATENCY >= SPLIT_THRESHOLD);
`else
    // Split hardware absent: the threshold only keeps the parameter list uniform.
    localparam logic SPLIT_ON_C = (READ_LATENCY >= SPLIT_THRESHOLD) & 1'b0;
`endif

    slave_state_t          state_r, state_s;
    logic                  mode_r, mode_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [DATA_WIDTH-1:0] data_r, data_s;
    logic [DATA_WIDTH-1:0] tx_r, tx_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [WAIT_W-1:0]     wait_r, wait_s;
    logic                  slave_ready_r, slave_valid_r, split_r;
    logic                  in_accept_s, out_accept_s;
    logic [DATA_WIDTH-1:0] rdata_s;
    logic                  mem_we_s;

    assign in_accept_s  = master_valid & slave_ready_r;
    assign out_accept_s = slave_valid_r & master_ready;
    assign mem_we_s     = (state_r == WRITE);

    assign slave_ready = slave_ready_r;
    assign slave_valid = slave_valid_r;
    assign split       = split_r;
    assign rd_bus      = tx_r[DATA_WIDTH-1];

    slave_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bram (
        .clk   (clk),
        .we    (mem_we_s),
        .addr  (addr_r),
        .wdata (data_r),
        .rdata (rdata_s)
    );

    // Next-state, shift-register and counter update for the transfer sequence.
    always_comb begin
        state_s = state_r;
        mode_s  = mode_r;
        addr_s  = addr_r;
        data_s  = data_r;
        tx_s    = tx_r;
        cnt_s   = cnt_r;
        wait_s  = wait_r;
        case (state_r)
            IDLE: begin
                if (in_accept_s) begin
                    mode_s = mode;
                    addr_s = (addr_r << 1'b1) | ADDR_WIDTH'(wr_bus);
                    if (ADDR_WIDTH == 1) begin
                        cnt_s   = '0;
                        wait_s  = '0;
                        state_s = (mode == MODE_WRITE) ? RX_DATA : READ_WAIT;
                    end else begin
                        cnt_s   = CNT_ONE_C;
                        state_s = RX_ADDR;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RX_ADDR: begin
                if (in_accept_s) begin
                    addr_s = (addr_r << 1'b1) | ADDR_WIDTH'(wr_bus);
                    if (cnt_r == ADDR_LAST_C) begin
                        cnt_s   = '0;
                        wait_s  = '0;
                        state_s = (mode_r == MODE_WRITE) ? RX_DATA : READ_WAIT;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE_C;
                    end
                end else begin
                    state_s = RX_ADDR;
                end
            end
            RX_DATA: begin
                if (in_accept_s) begin
                    data_s = (data_r << 1'b1) | DATA_WIDTH'(wr_bus);
                    if (cnt_r == DATA_LAST_C) begin
                        cnt_s   = '0;
                        state_s = WRITE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE_C;
                    end
                end else begin
                    state_s = RX_DATA;
                end
            end
            WRITE: begin
                state_s = IDLE;
            end
            READ_WAIT: begin
                // READ_WAIT spans READ_LATENCY cycles; the load happens on its last one.
                if (wait_r == WAIT_LAST_C) begin
                    tx_s    = rdata_s;
                    cnt_s   = '0;
                    state_s = TX_DATA;
                end else begin
                    wait_s = wait_r + WAIT_ONE_C;
                end
            end
            TX_DATA: begin
                if (out_accept_s) begin
                    tx_s = tx_r << 1'b1;
                    if (cnt_r == DATA_LAST_C) begin
                        cnt_s   = '0;
                        state_s = IDLE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE_C;
                    end
                end else begin
                    state_s = TX_DATA;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            mode_r        <= MODE_READ;
            addr_r        <= '0;
            data_r        <= '0;
            tx_r          <= '0;
            cnt_r         <= '0;
            wait_r        <= '0;
            slave_ready_r <= 1'b0;
            slave_valid_r <= 1'b0;
            split_r       <= 1'b0;
        end else begin
            state_r       <= state_s;
            mode_r        <= mode_s;
            addr_r        <= addr_s;
            data_r        <= data_s;
            tx_r          <= tx_s;
            cnt_r         <= cnt_s;
            wait_r        <= wait_s;
            slave_ready_r <= (state_s == IDLE) || (state_s == RX_ADDR) || (state_s == RX_DATA);
            slave_valid_r <= (state_s == TX_DATA);
            split_r       <= SPLIT_ON_C && (state_s == READ_WAIT);
        end
    end

endmodule

// File: tb/tb_serial_slave_port.sv
// Self-checking bench for serial_slave_port: transaction-level model plus directed tests.
module tb_serial_slave_port;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int RL    = 2;

`ifdef SERIAL_SLAVE_SPLIT_EN
    localparam bit SPLIT_EXP = (RL >= 2);
`else
    localparam bit SPLIT_EXP = 1'b0;
`endif

    logic clk, rst, mode, wr_bus, master_valid, master_ready;
    logic slave_ready, rd_bus, slave_valid, split;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_slave_port #(
        .DATA_WIDTH      (DW),
        .MEM_DEPTH       (DEPTH),
        .ADDR_WIDTH      (AW),
        .READ_LATENCY    (RL),
        .SPLIT_THRESHOLD (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .wr_bus       (wr_bus),
        .master_valid (master_valid),
        .slave_ready  (slave_ready),
        .rd_bus       (rd_bus),
        .slave_valid  (slave_valid),
        .master_ready (master_ready),
        .split        (split)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: memory image, bit counts, latency countdown, data queue.
    logic [7:0] ref_mem [DEPTH];
    logic       txq [$];
    int         rx_n = 0, rd_wait = 0, cur_addr = 0, cur_data = 0;
    bit         cur_mode = 1'b0, wr_pend = 1'b0, m_gap = 1'b1;
    bit         e_ready, e_valid, e_split;
    logic [7:0] word;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_slave_ready", slave_ready, 0);
            chk("rst_slave_valid", slave_valid, 0);
            chk("rst_split", split, 0);
            rx_n = 0; rd_wait = 0; wr_pend = 1'b0; m_gap = 1'b1;
            txq.delete();
        end else begin
            e_ready = !m_gap && !wr_pend && (rd_wait == 0) && (txq.size() == 0);
            e_valid = (rd_wait == 0) && (txq.size() != 0);
            e_split = SPLIT_EXP && (rd_wait != 0);
            chk("model_slave_ready", slave_ready, e_ready);
            chk("model_slave_valid", slave_valid, e_valid);
            chk("model_split", split, e_split);
            if (e_valid) chk("model_rd_bus", rd_bus, txq[0]);
            m_gap   = 1'b0;
            wr_pend = 1'b0;
            if (rd_wait != 0) rd_wait--;
            if (e_valid && master_ready) void'(txq.pop_front());
            if (e_ready && master_valid) begin
                if (rx_n == 0) begin
                    cur_mode = mode; cur_addr = 0; cur_data = 0;
                end
                if (rx_n < AW) cur_addr = cur_addr * 2 + int'(wr_bus);
                else           cur_data = cur_data * 2 + int'(wr_bus);
                rx_n++;
                if (rx_n == AW && !cur_mode) begin
                    word = (cur_addr < DEPTH) ? ref_mem[cur_addr] : 8'h00;
                    for (int i = DW - 1; i >= 0; i--) txq.push_back(word[i]);
                    rd_wait = RL;
                    rx_n    = 0;
                end else if (rx_n == AW + DW) begin
                    if (cur_addr < DEPTH) ref_mem[cur_addr] = cur_data[7:0];
                    wr_pend = 1'b1;
                    rx_n    = 0;
                end
            end
        end
    end

    // Present one bit and hold it until the slave takes it; starts and ends 1 time unit after a rising edge.
    task automatic send_bit(input logic b, input logic m);
        bit acc = 1'b0;
        int n = 0;
        wr_bus = b; mode = m; master_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = slave_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_bit_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input bit gaps);
        for (int i = AW - 1; i >= 0; i--) begin
            if (gaps) begin master_valid = 1'b0; @(posedge clk); #1; end
            send_bit(a[i], (i == AW - 1) ? 1'b1 : 1'b0);
        end
        for (int i = DW - 1; i >= 0; i--) begin
            if (gaps) begin master_valid = 1'b0; @(posedge clk); #1; end
            send_bit(d[i], 1'b0);
        end
        master_valid = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, input bit toggle, output logic [7:0] got,
                           output int lat, output int accepts, output int vcyc, output int scyc);
        bit   seen  = 1'b0;
        logic phase = 1'b1;
        int   n     = 0;
        for (int i = AW - 1; i >= 0; i--) send_bit(a[i], (i == AW - 1) ? 1'b0 : 1'b1);
        master_valid = 1'b0;
        got = 8'h00; lat = 0; accepts = 0; vcyc = 0; scyc = 0;
        while (accepts < DW && n < 100) begin
            master_ready = toggle ? phase : 1'b1;
            @(negedge clk);
            if (split) scyc++;
            if (slave_valid) begin
                seen = 1'b1;
                vcyc++;
                if (master_ready) begin
                    got = {got[6:0], rd_bus};
                    accepts++;
                end
            end else if (!seen) begin
                lat++;
            end
            @(posedge clk); #1;
            phase = ~phase;
            n++;
        end
        master_ready = 1'b0;
        if (accepts < DW) begin
            checks++; errors++;
            $display("FAIL read_timeout: got %0d accepts expected %0d", accepts, DW);
        end
    endtask

    initial begin
        logic [7:0] got;
        int lat, acc, vc, sc, t0;
        rst = 1'b1; mode = 1'b0; wr_bus = 1'b0; master_valid = 1'b0; master_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_ready", slave_ready, 0);
        chk("reset_valid", slave_valid, 0);
        chk("reset_split", split, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: write 0xA5 to 0x3 with valid held high
        t0 = cyc;
        do_write(4'h3, 8'hA5, 1'b0);
        chk("t1_cycles", cyc - t0, 12);
        @(negedge clk);
        chk("t1_write_cycle_ready", slave_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_ready_after_write", slave_ready, 1);
        @(posedge clk); #1;

        // 2: read 0x3, master always ready
        do_read(4'h3, 1'b0, got, lat, acc, vc, sc);
        chk("t2_data", got, 8'hA5);
        chk("t2_latency", lat, 2);
        chk("t2_accepts", acc, 8);
        chk("t2_valid_cycles", vc, 8);
        chk("t6_split_cycles", sc, SPLIT_EXP ? 2 : 0);

        // 3: back-to-back read with master_ready toggling
        do_read(4'h3, 1'b1, got, lat, acc, vc, sc);
        chk("t3_data", got, 8'hA5);
        chk("t3_accepts", acc, 8);
        chk("t3_valid_cycles", vc, 15);
        @(negedge clk);
        chk("t3_valid_drops", slave_valid, 0);
        @(posedge clk); #1;

        // 4: write 0x3C to 0x7 with gaps, then read back
        do_write(4'h7, 8'h3C, 1'b1);
        do_read(4'h7, 1'b0, got, lat, acc, vc, sc);
        chk("t4_data", got, 8'h3C);

        // 5: reset in the middle of RX_DATA of a write to 0x3
        for (int i = AW - 1; i >= 0; i--) send_bit(1'(4'h3 >> i), (i == AW - 1) ? 1'b1 : 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        #2 rst = 1'b1;
        master_valid = 1'b0;
        @(negedge clk);
        chk("t5_ready", slave_ready, 0);
        chk("t5_valid", slave_valid, 0);
        chk("t5_split", split, 0);
        chk("t5_rd_bus", rd_bus, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_read(4'h3, 1'b0, got, lat, acc, vc, sc);
        chk("t5_mem_kept", got, 8'hA5);
        do_write(4'hF, 8'h5A, 1'b0);
        do_read(4'hF, 1'b0, got, lat, acc, vc, sc);
        chk("t5_next_txn", got, 8'h5A);
        chk("t5_latency", lat, 2);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
